// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: phase encoding, widths and a
// helper that sizes the execute-phase cycle counter.
package fetch_sequencer_pkg;

  // Default program counter / memory address width
  localparam int ADDR_W_DEFAULT = 8;

  // Width of an opcode byte held in the instruction register
  localparam int OPCODE_W = 8;

  // Instruction phase encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2,
    ST_EXEC   = 2'd3
  } state_e;

  // Counter width able to hold 0 .. cycles-1; never narrower than one bit
  function automatic int exec_cnt_width(input int cycles);
    if (cycles <= 2) begin
      return 1;
    end
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/fetch_sequencer_program_counter.sv
// Program counter register: load (jump redirection) wins over increment,
// increment wraps modulo 2^ADDR_W, asynchronous reset to PC_RESET.
module program_counter
  import fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next pc: a taken jump overrides any increment in the same cycle
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_value;
    end else if (inc) begin
      pc_d = pc_q + 1'b1;
    end
  end

  // pc register with asynchronous reset to the configured start address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: walks each instruction through FETCH -> DECODE -> EXECUTE,
// captures the opcode into ir and owns the program counter. Every output is
// either a register or the pc register itself, so no input reaches an output
// combinationally.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] PC_RESET    = '0,
  parameter int                EXEC_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                halt_req,
  input  logic [OPCODE_W-1:0] mem_rdata,
  input  logic                mem_ready,
  input  logic                jump_taken,
  input  logic [ADDR_W-1:0]   jump_target,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [OPCODE_W-1:0] ir,
  output logic                decode,
  output logic                execute,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy
);

  localparam int CNT_W = exec_cnt_width(EXEC_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [OPCODE_W-1:0] ir_q;
  logic                mem_req_q;
  logic                decode_q;
  logic                execute_q;
  logic                busy_q;

  logic                fetch_done;
  logic                exec_last;
  logic                stop_req;
  logic                pc_inc;
  logic                pc_load;
  logic [ADDR_W-1:0]   pc_value;

  // Phase qualifiers shared by the FSM and the program counter
  always_comb begin
    fetch_done = (state_q == ST_FETCH) && mem_ready;
    exec_last  = (state_q == ST_EXEC) && (cnt_q == CNT_LAST);
    stop_req   = halt_req || !run;
    pc_inc     = fetch_done;
    pc_load    = exec_last && jump_taken;
  end

  program_counter #(
    .ADDR_W   (ADDR_W),
    .PC_RESET (PC_RESET)
  ) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (pc_inc),
    .load       (pc_load),
    .load_value (jump_target),
    .pc         (pc_value)
  );

  // Phase FSM with registered strobes, execute-cycle counter and ir capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ir_q      <= '0;
      mem_req_q <= 1'b0;
      decode_q  <= 1'b0;
      execute_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_q   <= ST_FETCH;
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_FETCH: begin
          // No timeout: memory may stall the fetch indefinitely
          if (mem_ready) begin
            state_q   <= ST_DECODE;
            ir_q      <= mem_rdata;
            mem_req_q <= 1'b0;
            decode_q  <= 1'b1;
          end
        end
        ST_DECODE: begin
          state_q   <= ST_EXEC;
          cnt_q     <= '0;
          decode_q  <= 1'b0;
          execute_q <= 1'b1;
        end
        ST_EXEC: begin
          if (exec_last) begin
            execute_q <= 1'b0;
            if (stop_req) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= ST_FETCH;
              mem_req_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
          decode_q  <= 1'b0;
          execute_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = pc_value;
  assign pc       = pc_value;
  assign ir       = ir_q;
  assign decode   = decode_q;
  assign execute  = execute_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (default parameters, and
// PC_RESET=FF / EXEC_CYCLES=3) share stimulus; a per-instance behavioural
// model is compared every cycle, with directed literal checks on top.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       halt_req = 1'b0;
  logic       mem_ready = 1'b0;
  logic       jump_taken = 1'b0;
  logic [7:0] jump_target = 8'h00;

  logic [7:0] mem [256];

  logic [7:0] rdata_a, addr_a, ir_a, pc_a;
  logic       req_a, dec_a, exe_a, busy_a;
  logic [7:0] rdata_b, addr_b, ir_b, pc_b;
  logic       req_b, dec_b, exe_b, busy_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rdata_a = mem[addr_a];
  assign rdata_b = mem[addr_b];

  fetch_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req),
    .mem_rdata(rdata_a), .mem_ready(mem_ready), .jump_taken(jump_taken),
    .jump_target(jump_target), .mem_req(req_a), .mem_addr(addr_a), .ir(ir_a),
    .decode(dec_a), .execute(exe_a), .pc(pc_a), .busy(busy_a)
  );

  fetch_sequencer #(.ADDR_W(8), .PC_RESET(8'hFF), .EXEC_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req),
    .mem_rdata(rdata_b), .mem_ready(mem_ready), .jump_taken(jump_taken),
    .jump_target(jump_target), .mem_req(req_b), .mem_addr(addr_b), .ir(ir_b),
    .decode(dec_b), .execute(exe_b), .pc(pc_b), .busy(busy_b)
  );

  logic       o_req [2];
  logic       o_dec [2];
  logic       o_exe [2];
  logic       o_busy[2];
  logic [7:0] o_addr[2];
  logic [7:0] o_pc  [2];
  logic [7:0] o_ir  [2];

  assign o_req[0] = req_a;  assign o_req[1] = req_b;
  assign o_dec[0] = dec_a;  assign o_dec[1] = dec_b;
  assign o_exe[0] = exe_a;  assign o_exe[1] = exe_b;
  assign o_busy[0] = busy_a; assign o_busy[1] = busy_b;
  assign o_addr[0] = addr_a; assign o_addr[1] = addr_b;
  assign o_pc[0] = pc_a;     assign o_pc[1] = pc_b;
  assign o_ir[0] = ir_a;     assign o_ir[1] = ir_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model per instance: phase 0 idle, 1 fetch, 2 decode, 3 execute
  for (genvar gi = 0; gi < 2; gi++) begin : g_model
    localparam int         EC = (gi == 0) ? 1 : 3;
    localparam logic [7:0] PR = (gi == 0) ? 8'h00 : 8'hFF;
    int         ph;
    int         left;
    logic [7:0] pc_m;
    logic [7:0] ir_m;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ph <= 0; left <= 0; pc_m <= PR; ir_m <= 8'h00;
      end else begin
        case (ph)
          0: if (run) ph <= 1;
          1: if (mem_ready) begin
               ir_m <= mem[pc_m];
               pc_m <= pc_m + 8'd1;
               ph   <= 2;
             end
          2: begin ph <= 3; left <= EC; end
          default: begin
            if (left == 1) begin
              if (jump_taken) pc_m <= jump_target;
              ph <= (halt_req || !run) ? 0 : 1;
            end else begin
              left <= left - 1;
            end
          end
        endcase
      end
    end

    always @(negedge clk) begin
      check($sformatf("i%0d.mem_req", gi), 32'(o_req[gi]), 32'(ph == 1));
      check($sformatf("i%0d.decode", gi), 32'(o_dec[gi]), 32'(ph == 2));
      check($sformatf("i%0d.execute", gi), 32'(o_exe[gi]), 32'(ph == 3));
      check($sformatf("i%0d.busy", gi), 32'(o_busy[gi]), 32'(ph != 0));
      check($sformatf("i%0d.mem_addr", gi), 32'(o_addr[gi]), 32'(pc_m));
      check($sformatf("i%0d.pc", gi), 32'(o_pc[gi]), 32'(pc_m));
      check($sformatf("i%0d.ir", gi), 32'(o_ir[gi]), 32'(ir_m));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse reset between tests; ends on a negedge with both DUTs idle
  task automatic do_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
    mem[8'h00] = 8'h12;
    mem[8'h01] = 8'h34;
    mem[8'hFF] = 8'hA5;

    // Reset state
    cyc(2);
    check("rst.pc_a", 32'(pc_a), 32'h00);
    check("rst.pc_b", 32'(pc_b), 32'hFF);
    check("rst.ir_a", 32'(ir_a), 32'h00);
    check("rst.strobes_a", 32'({req_a, dec_a, exe_a, busy_a}), 32'h0);
    #2 rst_n = 1'b1;
    cyc(1);

    // Straight-line fetch on a; wrap and 3-cycle execute with run drop on b
    run = 1'b1; mem_ready = 1'b1;
    cyc(1);
    check("sl.x1.req_a", 32'(req_a), 32'h1);
    check("sl.x1.addr_a", 32'(addr_a), 32'h00);
    check("wr.x1.addr_b", 32'(addr_b), 32'hFF);
    cyc(1);
    check("sl.x2.dec_a", 32'(dec_a), 32'h1);
    check("sl.x2.ir_a", 32'(ir_a), 32'h12);
    check("sl.x2.pc_a", 32'(pc_a), 32'h01);
    check("wr.x2.pc_b", 32'(pc_b), 32'h00);
    check("wr.x2.ir_b", 32'(ir_b), 32'hA5);
    nb = 0;
    cyc(1);
    check("sl.x3.exe_a", 32'(exe_a), 32'h1);
    check("sl.x3.dec_a", 32'(dec_a), 32'h0);
    nb += 32'(exe_b);
    cyc(1);
    check("sl.x4.req_a", 32'(req_a), 32'h1);
    check("sl.x4.addr_a", 32'(addr_a), 32'h01);
    nb += 32'(exe_b);
    run = 1'b0;
    cyc(1);
    check("sl.x5.dec_a", 32'(dec_a), 32'h1);
    check("sl.x5.ir_a", 32'(ir_a), 32'h34);
    check("sl.x5.pc_a", 32'(pc_a), 32'h02);
    nb += 32'(exe_b);
    cyc(1);
    nb += 32'(exe_b);
    check("mc.exec_cycles_b", 32'(nb), 32'd3);
    check("mc.x6.busy_b", 32'(busy_b), 32'h0);
    check("rs.x6.exe_a", 32'(exe_a), 32'h1);

    // Reset while a is executing aborts immediately
    #2 rst_n = 1'b0;
    #1;
    check("rs.pc_a", 32'(pc_a), 32'h00);
    check("rs.ir_a", 32'(ir_a), 32'h00);
    check("rs.strobes_a", 32'({req_a, dec_a, exe_a, busy_a}), 32'h0);
    cyc(1);
    #2 rst_n = 1'b1;
    cyc(3);
    check("rs.idle.busy_a", 32'(busy_a), 32'h0);
    check("rs.idle.req_a", 32'(req_a), 32'h0);

    // Memory wait: five fetch cycles, ready only on the last
    run = 1'b1; mem_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      check($sformatf("mw.x%0d.req_a", k), 32'(req_a), 32'h1);
      check($sformatf("mw.x%0d.addr_a", k), 32'(addr_a), 32'h00);
      check($sformatf("mw.x%0d.dec_a", k), 32'(dec_a), 32'h0);
      check($sformatf("mw.x%0d.ir_a", k), 32'(ir_a), 32'h00);
    end
    mem_ready = 1'b1;
    cyc(1);
    check("mw.x6.dec_a", 32'(dec_a), 32'h1);
    check("mw.x6.ir_a", 32'(ir_a), 32'h12);
    run = 1'b0;
    do_reset();

    // Jump taken on last execute cycle, then jump during DECODE ignored
    run = 1'b1; mem_ready = 1'b1;
    cyc(3);
    jump_taken = 1'b1; jump_target = 8'h40;
    cyc(1);
    check("jp.x4.addr_a", 32'(addr_a), 32'h40);
    check("jp.x4.req_a", 32'(req_a), 32'h1);
    jump_taken = 1'b0;
    cyc(1);
    jump_taken = 1'b1; jump_target = 8'h80;
    cyc(1);
    check("jp.x6.pc_a", 32'(pc_a), 32'h41);
    jump_taken = 1'b0;
    cyc(1);
    check("jp.x7.addr_a", 32'(addr_a), 32'h41);
    run = 1'b0;
    do_reset();

    // Halt during DECODE ignored; halt on last execute cycle goes idle
    run = 1'b1;
    cyc(2);
    halt_req = 1'b1;
    cyc(1);
    halt_req = 1'b0;
    cyc(1);
    check("ht.x4.req_a", 32'(req_a), 32'h1);
    check("ht.x4.busy_a", 32'(busy_a), 32'h1);
    cyc(2);
    halt_req = 1'b1;
    cyc(1);
    check("ht.x7.busy_a", 32'(busy_a), 32'h0);
    check("ht.x7.req_a", 32'(req_a), 32'h0);
    halt_req = 1'b0; run = 1'b0;
    do_reset();

    // Randomised traffic, model-checked every cycle
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      run         = ($urandom_range(0, 7) != 0);
      halt_req    = ($urandom_range(0, 9) == 0);
      mem_ready   = ($urandom_range(0, 9) < 6);
      jump_taken  = ($urandom_range(0, 9) < 3);
      jump_target = 8'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      cyc(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
